// File: rtl/iterative_shift_unit.sv
// Iterative sll/srl/sra: one shift-by-2 or shift-by-1 step per cycle, done_o after ceil(shamt/2)+1 edges.
// No backpressure: start_i is taken only in IDLE/DONE and dropped (not queued) while busy_o is high.
module iterative_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   data_o
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] rem;

  logic               step_two;
  logic [WIDTH-1:0]   step_data;
  logic [SHAMT_W-1:0] step_rem;

  // Single shared stage: moves by 2 while at least 2 remain, then by 1 for an odd tail.
  always_comb begin
    step_two  = (rem >= SHAMT_W'(2));
    step_data = data_o;
    step_rem  = '0;
    if (step_two) step_rem = rem - SHAMT_W'(2);
    case (op_q)
      OP_SLL: step_data = step_two ? {data_o[WIDTH-3:0], 2'b00}
                                   : {data_o[WIDTH-2:0], 1'b0};
      OP_SRL: step_data = step_two ? {2'b00, data_o[WIDTH-1:2]}
                                   : {1'b0, data_o[WIDTH-1:1]};
      OP_SRA: step_data = step_two ? {{2{data_o[WIDTH-1]}}, data_o[WIDTH-1:2]}
                                   : {data_o[WIDTH-1], data_o[WIDTH-1:1]};
      default: step_data = data_o;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      op_q   <= OP_SLL;
      rem    <= '0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            data_o <= data_i;
            op_q   <= op_i;
            rem    <= shamt_i;
            if ((shamt_i == '0) || (op_i == OP_PASS)) state <= DONE;
            else                                      state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          data_o <= step_data;
          rem    <= step_rem;
          if (step_rem == '0) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state == SHIFT);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed and random checks of iterative_shift_unit against reference shift operators, including latency.
module tb_iterative_shift_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  iterative_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [4:0] s);
    if (op == 2'b11 || s == 5'd0) return 1;
    return (int'(s) + 1) / 2 + 1;
  endfunction

  // Drives a start request (sampled at the next rising edge) and records the expected outcome.
  task automatic start_op(input string tag, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    start_i = 1'b1;
    op_i    = op;
    data_i  = d;
    shamt_i = s;
    e.data  = ref_shift(op, d, s);
    e.lat   = ref_lat(op, s);
    e.tag   = tag;
    sb_q.push_back(e);
  endtask

  // Waits for done_o, counting edges from acceptance; optionally pokes start_i mid-shift.
  task automatic wait_result(input bit noise);
    int   n;
    bit   got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk_i);
      n++;
      #1;
      if (n == 1) begin
        start_i = noise;
        if (noise) begin
          op_i    = 2'($urandom_range(0, 3));
          data_i  = $urandom;
          shamt_i = 5'($urandom_range(0, 31));
        end
      end
      if (n == 2) start_i = 1'b0;
      if (done_o) got = 1'b1;
      else chk("busy_during_shift", 32'(busy_o), 32'd1);
    end
    start_i = 1'b0;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
        chk({e.tag, "_data"}, data_o, e.data);
        chk({e.tag, "_latency"}, 32'(n), 32'(e.lat));
        chk({e.tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
      end
    end
  endtask

  initial begin
    int busy_cnt;
    bit done_seen;
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    data_i  = '0;
    shamt_i = '0;
    #1;
    chk("reset_data", data_o, 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("idle_done", 32'(done_o), 32'd0);

    // sll 0xF by 5: three shifting cycles.
    start_op("sll5", 2'b00, 32'h0000000F, 5'd5);
    wait_result(1'b0);
    chk("sll5_value", data_o, 32'h000001E0);

    start_op("sra31", 2'b10, 32'h80000000, 5'd31);
    wait_result(1'b0);
    chk("sra31_value", data_o, 32'hFFFFFFFF);
    @(posedge clk_i); #1;
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("result_hold", data_o, 32'hFFFFFFFF);

    start_op("srl31", 2'b01, 32'h80000000, 5'd31);
    wait_result(1'b0);
    chk("srl31_value", data_o, 32'h00000001);
    @(posedge clk_i); #1;

    start_op("sll31", 2'b00, 32'h00000001, 5'd31);
    wait_result(1'b0);
    chk("sll31_value", data_o, 32'h80000000);
    @(posedge clk_i); #1;

    start_op("sll0", 2'b00, 32'h12345678, 5'd0);
    wait_result(1'b0);
    chk("sll0_value", data_o, 32'h12345678);
    @(posedge clk_i); #1;

    start_op("pass", 2'b11, 32'hDEADBEEF, 5'd7);
    wait_result(1'b0);
    chk("pass_value", data_o, 32'hDEADBEEF);
    @(posedge clk_i); #1;

    // Start during SHIFT is dropped; then a back-to-back start from DONE.
    start_op("ignored_start", 2'b10, 32'hC0000000, 5'd9);
    wait_result(1'b1);
    chk("ignored_value", data_o, 32'hFFE00000);
    start_op("b2b_srl4", 2'b01, 32'hF0000000, 5'd4);
    wait_result(1'b0);
    chk("b2b_value", data_o, 32'h0F000000);
    @(posedge clk_i); #1;
    chk("after_b2b_idle", 32'(done_o), 32'd0);

    // Busy duration for shamt 5.
    start_op("sll5_busy", 2'b00, 32'h0000000F, 5'd5);
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (busy_o) busy_cnt++;
    end
    chk("sll5_busy_cycles", 32'(busy_cnt), 32'd3);
    void'(sb_q.pop_front());

    // Asynchronous reset in the middle of a shamt-20 operation.
    start_op("rst_mid", 2'b00, 32'hA5A5A5A5, 5'd20);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_mid_data", data_o, 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_done", 32'(done_o), 32'd0);
    #4 rst_i = 1'b0;
    sb_q.delete();
    done_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) done_seen = 1'b1;
    end
    chk("rst_mid_no_done", 32'(done_seen), 32'd0);

    start_op("post_rst_sll1", 2'b00, 32'h00000001, 5'd1);
    wait_result(1'b0);
    chk("post_rst_value", data_o, 32'h00000002);

    // Random regression with random gaps, back-to-back starts and ignored mid-shift starts.
    for (int k = 0; k < 1000; k++) begin
      logic [1:0]  rop;
      logic [31:0] rd;
      logic [4:0]  rs;
      rop = 2'($urandom_range(0, 3));
      rd  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 2)) begin
        @(posedge clk_i); #1;
      end
      start_op("rand", rop, rd, rs);
      wait_result(($urandom_range(0, 3) == 0) && (ref_lat(rop, rs) >= 3));
    end

    @(posedge clk_i); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
